// File: rtl/lrn_window_unit_pkg.sv
// Shared types and helpers for the LRN window unit: FSM state encoding,
// default parameter values and the unsigned saturation function.
package lrn_pkg;

  localparam int LRN_DATA_WIDTH  = 16;
  localparam int LRN_WIN_SIZE    = 5;
  localparam int LRN_ACC_WIDTH   = 40;
  localparam int LRN_FRAC_BITS   = 8;
  localparam int LRN_ALPHA_SHIFT = 4;
  localparam int LRN_K_CONST     = 2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DIVIDE,
    HOLD,
    GAP
  } lrn_win_state_t;

  // Clamp an unsigned value to the largest number representable in width bits.
  function automatic logic [63:0] sat_u(input logic [63:0] quotient, input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (quotient > max_val) ? max_val : quotient;
  endfunction

endpackage

// File: rtl/lrn_window_unit_if.sv
// Handshake bundle between the LRN window unit and the memory/address mapper side.
interface lrn_window_unit_if
  import lrn_pkg::*;
#(
  parameter int DATA_WIDTH = LRN_DATA_WIDTH
);
  logic                  start_normalization;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full_flag;
  logic                  div_out_valid;
  logic [DATA_WIDTH-1:0] div_out;
  logic                  normalized_window;
  logic                  seq_err;

  modport master (
    output start_normalization, rd_valid, rd_data,
    input  full_flag, div_out_valid, div_out, normalized_window, seq_err
  );

  modport slave (
    input  start_normalization, rd_valid, rd_data,
    output full_flag, div_out_valid, div_out, normalized_window, seq_err
  );
endinterface

// File: rtl/lrn_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step runs
// on the start edge so done rises exactly DIVIDEND_WIDTH cycles after start.
module lrn_seq_divider #(
  parameter int DIVIDEND_WIDTH = 24,
  parameter int DIVISOR_WIDTH  = 40
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  logic [DIVISOR_WIDTH-1:0]  rem_reg, rem_next, rem_in;
  logic [DIVISOR_WIDTH-1:0]  dsr_reg, dsr_in;
  logic [DIVIDEND_WIDTH-1:0] quo_reg, quo_next, quo_in;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      busy_reg;
  logic [DIVISOR_WIDTH:0]    shifted;
  logic                      ge;

  // A start always seeds a fresh operation, even while busy.
  always_comb begin
    rem_in   = start ? '0 : rem_reg;
    quo_in   = start ? dividend : quo_reg;
    dsr_in   = start ? divisor : dsr_reg;
    shifted  = {rem_in, quo_in[DIVIDEND_WIDTH-1]};
    ge       = (shifted >= {1'b0, dsr_in});
    rem_next = ge ? (shifted[DIVISOR_WIDTH-1:0] - dsr_in) : shifted[DIVISOR_WIDTH-1:0];
    quo_next = {quo_in[DIVIDEND_WIDTH-2:0], ge};
  end

  always_ff @(posedge core_clk) begin
    if (!reset) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= rem_next;
      quo_reg  <= quo_next;
      dsr_reg  <= divisor;
      cnt_reg  <= CNT_W'(DIVIDEND_WIDTH - 1);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      if (cnt_reg != '0) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - 1'b1;
      end else begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign done     = busy_reg && (cnt_reg == '0);
  assign quotient = quo_reg;

endmodule

// File: rtl/lrn_window_unit.sv
// Buffers one LRN window, accumulates its sum of squares, then divides each
// sample by the window energy term and streams saturated results to the mapper.
module lrn_window_unit
  import lrn_pkg::*;
#(
  parameter int DATA_WIDTH  = LRN_DATA_WIDTH,
  parameter int WIN_SIZE    = LRN_WIN_SIZE,
  parameter int ACC_WIDTH   = LRN_ACC_WIDTH,
  parameter int FRAC_BITS   = LRN_FRAC_BITS,
  parameter int ALPHA_SHIFT = LRN_ALPHA_SHIFT,
  parameter int K_CONST     = LRN_K_CONST
) (
  input  logic              core_clk,
  input  logic              reset,
  lrn_window_unit_if.slave  bus
);

  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(WIN_SIZE + 1);
  localparam int IDX_W = $clog2(WIN_SIZE);

  lrn_win_state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0]   sample_buf [WIN_SIZE];
  logic [CNT_W-1:0]        cnt_reg;
  logic [ACC_WIDTH-1:0]    acc_reg;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    seq_err_reg;
  logic                    first_start_reg;

  logic                    take_sample, last_sample, last_idx;
  logic                    div_start, div_done;
  logic                    full_flag, div_out_valid, normalized_window;
  logic [N-1:0]            dividend, quotient;
  logic [ACC_WIDTH-1:0]    divisor;
  logic [2*DATA_WIDTH-1:0] square;

  assign take_sample = (state_reg == FILL) && bus.rd_valid;
  assign last_sample = take_sample && (cnt_reg == CNT_W'(WIN_SIZE - 1));
  assign last_idx    = (idx_reg == IDX_W'(WIN_SIZE - 1));
  assign square      = (2*DATA_WIDTH)'(bus.rd_data) * (2*DATA_WIDTH)'(bus.rd_data);

  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    div_start         = 1'b0;
    full_flag         = 1'b0;
    div_out_valid     = 1'b0;
    normalized_window = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start_normalization) state_next = FILL;
      end
      FILL: begin
        if (last_sample) begin
          state_next = DIVIDE;
          idx_next   = '0;
        end
      end
      DIVIDE: begin
        full_flag     = 1'b1;
        div_start     = first_start_reg;
        div_out_valid = div_done;
        if (div_done) state_next = HOLD;
      end
      HOLD: begin
        full_flag = 1'b1;
        if (!last_idx) begin
          idx_next   = idx_reg + 1'b1;
          div_start  = 1'b1;
          state_next = DIVIDE;
        end else begin
          state_next = GAP;
        end
      end
      GAP: begin
        normalized_window = 1'b1;
        state_next        = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      acc_reg         <= '0;
      idx_reg         <= '0;
      seq_err_reg     <= 1'b0;
      first_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      first_start_reg <= last_sample;
      if (take_sample) begin
        cnt_reg <= cnt_reg + 1'b1;
        acc_reg <= acc_reg + ACC_WIDTH'(square);
      end else if (state_reg == GAP) begin
        cnt_reg <= '0;
        acc_reg <= '0;
      end
      if (bus.rd_valid && (state_reg != FILL)) seq_err_reg <= 1'b1;
    end
  end

  // Buffer contents survive reset; they are always rewritten before use.
  for (genvar gi = 0; gi < WIN_SIZE; gi++) begin : g_buf
    always_ff @(posedge core_clk) begin
      if (take_sample && (cnt_reg[IDX_W-1:0] == IDX_W'(gi))) sample_buf[gi] <= bus.rd_data;
    end
  end

  assign dividend = {sample_buf[idx_next], {FRAC_BITS{1'b0}}};
  assign divisor  = ACC_WIDTH'(K_CONST) + (acc_reg >> ALPHA_SHIFT);

  lrn_seq_divider #(
    .DIVIDEND_WIDTH (N),
    .DIVISOR_WIDTH  (ACC_WIDTH)
  ) u_div (
    .core_clk (core_clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );

  assign bus.full_flag         = full_flag;
  assign bus.div_out_valid     = div_out_valid;
  assign bus.div_out           = div_out_valid ? DATA_WIDTH'(sat_u(64'(quotient), DATA_WIDTH)) : '0;
  assign bus.normalized_window = normalized_window;
  assign bus.seq_err           = seq_err_reg;

endmodule

// File: doc/lrn_window_unit.md
Name: lrn_window_unit

Overview:
- Feeds the LRN address mapper.
- Captures the read-data stream of one normalization window into a local buffer and accumulates its sum of squares.
- For each buffered sample, computes x·2^FRAC_BITS / (K_CONST + (sum_sq >> ALPHA_SHIFT)) on a sequential divider.
- Drives the mapper's full_flag / div_out_valid / normalized_window handshake and supplies the write data.

Parameters:
- DATA_WIDTH, 16: unsigned sample and result width.
- WIN_SIZE, 5: samples per window. Legal range 2..32.
- ACC_WIDTH, 40: sum-of-squares accumulator width. Must be ≥ 2·DATA_WIDTH + clog2(WIN_SIZE).
- FRAC_BITS, 8: left shift applied to the dividend.
- ALPHA_SHIFT, 4: right shift applied to sum_sq, in the range 0..ACC_WIDTH-1.
- K_CONST, 2: bias added to the denominator. Must be ≥ 1, so the divisor is never zero.

Ports:
- core_clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start_normalization  in  1  layer start; sampled only in IDLE.
- rd_valid  in  1  rd_data valid this cycle.
- rd_data  in  DATA_WIDTH  sample from memory.
- full_flag  out  1  window buffer holds WIN_SIZE samples.
- div_out_valid  out  1  one-cycle pulse: div_out valid.
- div_out  out  DATA_WIDTH  normalized sample, saturated.
- normalized_window  out  1  one-cycle pulse: window finished.
- seq_err  out  1  sticky flag: rd_valid arrived outside FILL.

Behaviour:
- Reset (reset==0 at a clock edge, checked at any time, including mid-divide):
  - state goes to IDLE.
  - All outputs are 0.
  - fill count, accumulator and output index are cleared.
  - Buffer contents are don't-care.
- FSM states: IDLE, FILL, DIVIDE, HOLD, GAP.
- IDLE:
  - start_normalization=1 → FILL.
  - Otherwise stay in IDLE.
- FILL:
  - Each rd_valid writes buf[cnt] = rd_data, adds rd_data² (zero-extended to ACC_WIDTH) to acc, and increments cnt.
  - When the WIN_SIZE-th sample is taken:
    - Go to DIVIDE.
    - full_flag = 1 from the next cycle.
    - Issue a divider start with idx = 0 in that same next cycle.
- DIVIDE:
  - Divider start is a one-cycle pulse.
  - Dividend = buf[idx] << FRAC_BITS (DATA_WIDTH+FRAC_BITS bits).
  - Divisor = K_CONST + (acc >> ALPHA_SHIFT), ACC_WIDTH bits, no wrap.
  - The divider asserts done exactly N = DATA_WIDTH+FRAC_BITS cycles after start.
  - In the done cycle:
    - div_out_valid = 1.
    - div_out = min(quotient, 2^DATA_WIDTH-1), saturating.
- HOLD (the cycle after done):
  - If idx < WIN_SIZE-1: idx++, start the next divide, return to DIVIDE. Per-sample period is N+1 cycles.
  - Otherwise → GAP.
- GAP:
  - normalized_window pulses high for exactly one cycle, 2 cycles after the final div_out_valid.
  - In that same cycle: full_flag drops to 0, cnt and acc are cleared, state returns to FILL.
- Stream end: the block does not count windows. It stays in the FILL/DIVIDE loop until reset.
- rd_valid while not in FILL:
  - The data is dropped.
  - seq_err sets and stays 1 until reset.
- start_normalization outside IDLE is ignored.
- Width rules:
  - Squares are computed at 2·DATA_WIDTH bits.
  - The accumulator cannot overflow, given the ACC_WIDTH constraint.
  - The quotient is computed at full DATA_WIDTH+FRAC_BITS width before saturation.
- Full latency, with the last rd_valid at cycle T:
  - full_flag rises at T+1.
  - First div_out_valid at T+1+N.
  - The k-th output (k = 0..WIN_SIZE-1) at T+1+N+k(N+1).

Decomposition:
- Package lrn_pkg holds:
  - lrn_win_state_t enum (IDLE, FILL, DIVIDE, HOLD, GAP).
  - Default-parameter localparams.
  - A function sat_u(quotient, width).
- Sub-module lrn_seq_divider: unsigned restoring divider, one quotient bit per cycle.
  - Ports: start, dividend, divisor, done, quotient.
  - Parameters: dividend width, divisor width.
  - Same clock and reset as the parent.
  - A start while busy restarts the operation.

Test Plan (WIN_SIZE=5, DATA_WIDTH=16, FRAC_BITS=8, ACC_WIDTH=40; N=24):
- Reset held, then released with no start → every output 0 for 50 cycles. A start pulse followed by 5 rd_valid (data=1, K=1, ALPHA_SHIFT=0) → full_flag rises the cycle after the 5th sample.
- Same run, continued → 5 div_out_valid pulses, each div_out=42 (256/6), spaced 25 cycles apart. The first is 24 cycles after full_flag rises. normalized_window pulses 2 cycles after the 5th output and full_flag falls in the same cycle.
- All-zero window, K=1 → five outputs of 0. A second window of 1s follows immediately and yields 42 ×5, showing acc cleared between windows.
- ALPHA_SHIFT=39, K=1, samples {0x0100,0,0,0,0} → first output saturates to 0xFFFF (raw 0x10000); remaining outputs 0.
- rd_valid pulsed during DIVIDE → seq_err=1 and stays 1. Output sequence is unchanged.
- reset asserted mid-DIVIDE (cycle 10 of a divide) → next cycle all outputs 0 and state IDLE. A new start plus window then produces correct results with no stale outputs.
